flappy_input_port: RTL and testbench



---
 rtl/flappy_io_pkg.sv | 26 ++
 rtl/flappy_input_port_if.sv | 23 ++
 rtl/button_debouncer.sv | 57 +++++
 rtl/flappy_input_port.sv | 118 +++++++++++
 tb/tb_flappy_input_port.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flappy_io_pkg.sv
// Shared constants and types for the flappy input port: register offsets,
// status word bit positions and the button index order.
package flappy_io_pkg;

  // Word offsets from BASE_ADDR
  localparam int unsigned STATUS_OFS    = 0;
  localparam int unsigned CNT_UP_OFS    = 1;
  localparam int unsigned CNT_DOWN_OFS  = 2;
  localparam int unsigned CNT_RIGHT_OFS = 3;
  localparam int unsigned CNT_LEFT_OFS  = 4;

  // Status word layout
  localparam int unsigned LVL_LSB  = 0;
  localparam int unsigned FLAG_LSB = 4;
  localparam int unsigned COL_BIT  = 8;

  localparam int unsigned NUM_BTN = 4;

  typedef enum logic [1:0] {
    BTN_UP,
    BTN_DOWN,
    BTN_RIGHT,
    BTN_LEFT
  } btn_e;

endpackage

// File: rtl/flappy_input_port_if.sv
// Processor read port into the flappy input peripheral.
interface flappy_input_port_if;

  logic        rd_en;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_hit;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_hit
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_hit
  );

endinterface

// File: rtl/button_debouncer.sv
// One push-button: 2-FF synchroniser, counting debouncer and a single-cycle
// pulse on the debounced 0->1 transition.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_LOW,
    ST_HIGH
  } state_e;

  logic [1:0]    sync_q;
  logic          synced;
  state_e        state_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign synced = sync_q[1];

  // Debounce FSM: the state is the debounced level; a full run of mismatching
  // samples flips it, any agreeing sample restarts the run
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
    end else if (synced == (state_q == ST_HIGH)) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      state_q <= (state_q == ST_HIGH) ? ST_LOW : ST_HIGH;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign level = (state_q == ST_HIGH);
  // High in the cycle whose closing edge raises the level
  assign press = (state_q == ST_LOW) && synced && (cnt_q == CNT_MAX);

endmodule

// File: rtl/flappy_input_port.sv
// Memory-mapped input peripheral: debounced buttons, sticky press/collision
// flags with read-to-clear, press counters and a registered read port.
module flappy_input_port
  import flappy_io_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR       = 12'hFF0,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                up,
  input  logic                down,
  input  logic                right,
  input  logic                left,
  input  logic                collided,
  flappy_input_port_if.slave  bus,
  output logic                event_pending
);

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;

  logic [NUM_BTN-1:0] flag_q;
  logic               col_q;
  logic               col_d_q;
  logic               col_evt;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];

  logic [11:0] ofs;
  logic        clr;
  logic [31:0] status;
  logic [31:0] rd_word;
  logic        hit;
  logic [31:0] rd_data_q;
  logic        rd_hit_q;

  assign raw_btn = {left, right, down, up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock(clock),
      .reset(reset),
      .raw  (raw_btn[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  assign col_evt = collided & ~col_d_q;
  assign ofs     = bus.rd_addr - BASE_ADDR;
  assign clr     = bus.rd_en && (ofs == 12'(STATUS_OFS));

  // Assemble the status word from live levels and sticky flags
  always_comb begin
    status                   = '0;
    status[LVL_LSB +: 4]     = level;
    status[FLAG_LSB +: 4]    = flag_q;
    status[COL_BIT]          = col_q;
  end

  // Read address decode
  always_comb begin
    rd_word = '0;
    hit     = 1'b1;
    case (ofs)
      12'(STATUS_OFS):    rd_word = status;
      12'(CNT_UP_OFS):    rd_word[CNT_W-1:0] = cnt_q[BTN_UP];
      12'(CNT_DOWN_OFS):  rd_word[CNT_W-1:0] = cnt_q[BTN_DOWN];
      12'(CNT_RIGHT_OFS): rd_word[CNT_W-1:0] = cnt_q[BTN_RIGHT];
      12'(CNT_LEFT_OFS):  rd_word[CNT_W-1:0] = cnt_q[BTN_LEFT];
      default:            hit = 1'b0;
    endcase
  end

  // Sticky flags and counters; a new event in the clearing cycle survives
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_q  <= '0;
      col_q   <= 1'b0;
      col_d_q <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      col_d_q <= collided;
      if (clr) begin
        flag_q <= press;
        col_q  <= col_evt;
      end else begin
        flag_q <= flag_q | press;
        col_q  <= col_q | col_evt;
      end
      for (int i = 0; i < NUM_BTN; i++) begin
        if (press[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  // Registered read port; data holds between reads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else if (bus.rd_en) begin
      rd_data_q <= rd_word;
      rd_hit_q  <= hit;
    end else begin
      rd_hit_q  <= 1'b0;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_hit    = rd_hit_q;
  assign event_pending = (|flag_q) | col_q;

endmodule

// File: tb/tb_flappy_input_port.sv
// Randomised and directed bench for flappy_input_port with a scoreboard fed
// by a behavioural model of buttons, flags, counters and the read port.
module tb_flappy_input_port;

  localparam logic [11:0] BASE = 12'hFF0;
  localparam int DC = 8;
  // Narrow counters so the wrap can be reached with real presses
  localparam int CW = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = 4'b0000;   // {left,right,down,up}
  logic       collided = 1'b0;
  logic       event_pending;

  flappy_input_port_if bus ();

  flappy_input_port #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .up           (btn[0]),
    .down         (btn[1]),
    .right        (btn[2]),
    .left         (btn[3]),
    .collided     (collided),
    .bus          (bus),
    .event_pending(event_pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        hit;
    logic        ep;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  // Behavioural model state
  logic [3:0]  m_s1, m_s2, m_lvl, m_flag;
  int          m_run [4];
  int          m_cnt [4];
  logic        m_col, m_cold;
  logic [31:0] m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_flag = '0;
    m_col = 1'b0; m_cold = 1'b0; m_rd = '0;
    for (int b = 0; b < 4; b++) begin
      m_run[b] = 0;
      m_cnt[b] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled,
  // queue the expected post-edge outputs, then step past the edge.
  task automatic tick();
    exp_t       e;
    logic [3:0] prs;
    logic       cev;
    logic       hit;
    int         ofs;
    prs = '0;
    hit = 1'b0;
    ofs = -1;
    if (reset) begin
      model_clear();
    end else begin
      if (bus.rd_en) begin
        ofs = int'(bus.rd_addr) - int'(BASE);
        hit = (ofs >= 0) && (ofs <= 4);
        if (ofs == 0)  m_rd = {23'd0, m_col, m_flag, m_lvl};
        else if (hit)  m_rd = 32'(m_cnt[ofs-1]);
        else           m_rd = '0;
      end
      for (int b = 0; b < 4; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            m_lvl[b] = ~m_lvl[b];
            m_run[b] = 0;
            prs[b]   = m_lvl[b];
          end
        end else begin
          m_run[b] = 0;
        end
      end
      cev    = collided && !m_cold;
      m_cold = collided;
      if (bus.rd_en && ofs == 0) begin
        m_flag = '0;
        m_col  = 1'b0;
      end
      m_flag = m_flag | prs;
      m_col  = m_col | cev;
      for (int b = 0; b < 4; b++) begin
        if (prs[b]) m_cnt[b] = (m_cnt[b] + 1) % (1 << CW);
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
    e.data = m_rd;
    e.hit  = hit;
    e.ep   = (|m_flag) | m_col;
    exp_q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  // Scoreboard monitor: one expectation per clock edge
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_rd_data", bus.rd_data, e.data);
      chk("sb_rd_hit", 32'(bus.rd_hit), 32'(e.hit));
      chk("sb_event_pending", 32'(event_pending), 32'(e.ep));
    end
  end

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input logic [11:0] addr);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_en   = 1'b0;
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    idle(hold);
    btn[b] = 1'b0;
    idle(12);
  endtask

  initial begin
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    model_clear();

    // Reset state
    idle(3);
    chk("reset_rd_data", bus.rd_data, 32'd0);
    chk("reset_rd_hit", 32'(bus.rd_hit), 32'd0);
    chk("reset_event_pending", 32'(event_pending), 32'd0);
    reset = 1'b0;
    idle(3);

    // Debounce and counter
    press(0, 20);
    rd(BASE + 12'd1);
    chk("up_count_1", bus.rd_data, 32'd1);
    rd(BASE);
    chk("up_flag_set", 32'(bus.rd_data[4]), 32'd1);
    press(0, 20);
    rd(BASE + 12'd1);
    chk("up_count_2", bus.rd_data, 32'd2);
    rd(BASE);

    // Glitch rejection
    btn[1] = 1'b1;
    idle(5);
    btn[1] = 1'b0;
    idle(14);
    chk("glitch_event_pending", 32'(event_pending), 32'd0);
    rd(BASE + 12'd2);
    chk("glitch_down_count", bus.rd_data, 32'd0);
    rd(BASE);
    chk("glitch_status", bus.rd_data, 32'd0);

    // Read-to-clear
    press(3, 20);
    rd(BASE);
    chk("left_flag_read", 32'(bus.rd_data[7]), 32'd1);
    chk("left_flag_hit", 32'(bus.rd_hit), 32'd1);
    rd(BASE);
    chk("left_flag_cleared", 32'(bus.rd_data[7]), 32'd0);
    chk("cleared_event_pending", 32'(event_pending), 32'd0);

    // Set-wins race: status read in the cycle of the right press pulse
    begin
      bit hit_race = 1'b0;
      btn[2] = 1'b1;
      for (int i = 0; i < 40 && !hit_race; i++) begin
        if (!m_lvl[2] && m_s2[2] && m_run[2] == DC - 1) begin
          rd(BASE);
          hit_race = 1'b1;
        end else begin
          tick();
        end
      end
      chk("race_reached", 32'(hit_race), 32'd1);
      chk("race_same_cycle", 32'(bus.rd_data[6]), 32'd0);
      rd(BASE);
      chk("race_next_read", 32'(bus.rd_data[6]), 32'd1);
      btn[2] = 1'b0;
      idle(14);
    end

    // Collision
    collided = 1'b1;
    idle(100);
    rd(BASE);
    chk("col_set", 32'(bus.rd_data[8]), 32'd1);
    idle(5);
    rd(BASE);
    chk("col_held_no_reset", 32'(bus.rd_data[8]), 32'd0);
    collided = 1'b0;
    idle(2);
    collided = 1'b1;
    idle(2);
    rd(BASE);
    chk("col_reraised", 32'(bus.rd_data[8]), 32'd1);
    collided = 1'b0;
    idle(2);

    // Reset mid-debounce abandons the press
    rd(BASE + 12'd3);
    chk("right_count_before_reset", bus.rd_data, 32'd1);
    btn[0] = 1'b1;
    for (int i = 0; i < 20 && m_run[0] != 5; i++) tick();
    chk("mid_debounce_reached", 32'(m_run[0]), 32'd5);
    reset = 1'b1;
    #1;
    chk("async_reset_rd_data", bus.rd_data, 32'd0);
    chk("async_reset_event_pending", 32'(event_pending), 32'd0);
    idle(2);
    btn[0] = 1'b0;
    idle(1);
    reset = 1'b0;
    idle(14);
    chk("no_press_after_reset", 32'(event_pending), 32'd0);
    rd(BASE + 12'd1);
    chk("up_count_after_reset", bus.rd_data, 32'd0);

    // Decode boundaries
    rd(BASE + 12'd5);
    chk("oob_hi_hit", 32'(bus.rd_hit), 32'd0);
    chk("oob_hi_data", bus.rd_data, 32'd0);
    rd(BASE - 12'd1);
    chk("oob_lo_hit", 32'(bus.rd_hit), 32'd0);

    // Counter wrap
    for (int i = 0; i < 15; i++) press(0, 12);
    rd(BASE + 12'd1);
    chk("up_count_max", bus.rd_data, 32'd15);
    press(0, 12);
    rd(BASE + 12'd1);
    chk("up_count_wrap", bus.rd_data, 32'd0);
    rd(BASE);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
      end
      if ($urandom_range(0, 9) == 0) collided = ~collided;
      bus.rd_en   = ($urandom_range(0, 2) == 0);
      bus.rd_addr = ($urandom_range(0, 9) == 0) ? 12'($urandom)
                                                : BASE + 12'($urandom_range(0, 6));
      tick();
    end
    bus.rd_en = 1'b0;
    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
